// File: rtl/adder_share_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding and default sizes.
package adder_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module adder_share_arbiter_rr_pick
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0]    w_pos [NUM_REQ];
  logic [NUM_REQ-1:0] w_hit;

  // Candidate k is requester (ptr + k) mod NUM_REQ; ptr is always < NUM_REQ
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] w_sum;
      assign w_sum      = {1'b0, ptr} + (ID_W+1)'(gi);
      assign w_pos[gi]  = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                       : ID_W'(w_sum);
      assign w_hit[gi]  = req[w_pos[gi]];
    end
  endgenerate

  // Lowest candidate offset with its request set wins
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_hit[k]) idx = w_pos[k];
    end
  end

  assign any        = |req;
  assign gnt_onehot = any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/adder_share_arbiter.sv
// One 8-bit adder shared by NUM_REQ clients; round-robin grant, tagged result with valid/ready.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] a_in,
  input  logic [NUM_REQ*DATA_W-1:0] b_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W:0]           res_data,
  output logic [ID_W-1:0]           res_id
);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_valid;
  logic [DATA_W:0]     r_data;
  logic [ID_W-1:0]     r_id;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic [ID_W-1:0]     w_ptr_next;
  logic [DATA_W-1:0]   w_a_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_b_arr [NUM_REQ];

  // Unpack the flat operand buses so the winner can be selected by index
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = a_in[gi*DATA_W +: DATA_W];
      assign w_b_arr[gi] = b_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  adder_share_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (req),
    .ptr        (r_ptr),
    .gnt_onehot (w_pick_gnt),
    .idx        (w_pick_idx),
    .any        (w_pick_any)
  );

  assign w_ptr_next = (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

  // Arbitrate in IDLE, add in EXEC, hold the result in HOLD until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt <= '0;
          if (w_pick_any) begin
            r_a     <= w_a_arr[w_pick_idx];
            r_b     <= w_b_arr[w_pick_idx];
            r_id    <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_ptr   <= w_ptr_next;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_gnt   <= '0;
          r_data  <= {1'b0, r_a} + {1'b0, r_b};
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: hand-computed vectors per scenario.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_data;
  logic [1:0]  res_id;

  int vectors;
  int miscompares;
  logic gnt3_seen;

  adder_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (gnt[3]) gnt3_seen <= 1'b1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*8 +: 8] = a;
    b_in[i*8 +: 8] = b;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
    #12;
    vectors++;
    if ({gnt, busy, res_valid, res_data, res_id} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b busy=%b vld=%b data=%0d id=%0d, want all 0",
               gnt, busy, res_valid, res_data, res_id);
    end
    tick();
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_single;
    set_op(0, 8'd10, 8'd15);
    req = 4'b0001;
    tick();
    vectors++;
    if ({gnt, busy, res_valid} !== {4'b0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL t1_grant: gnt=%b busy=%b vld=%b, want 0001 1 0", gnt, busy, res_valid);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({gnt, res_valid, res_data, res_id} !== {4'b0000, 1'b1, 9'd25, 2'd0}) begin
      miscompares++;
      $display("FAIL t1_result: gnt=%b vld=%b data=%0d id=%0d, want 0000 1 25 0",
               gnt, res_valid, res_data, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if ({busy, res_valid, res_data} !== {1'b0, 1'b0, 9'd25}) begin
      miscompares++;
      $display("FAIL t1_accept: busy=%b vld=%b data=%0d, want 0 0 25", busy, res_valid, res_data);
    end
    $display("single: req0 10+15 -> %0d id %0d", res_data, res_id);
  endtask

  task automatic test_carry;
    set_op(2, 8'd255, 8'd255);
    req = 4'b0100;
    tick();
    vectors++;
    if ({gnt, res_id} !== {4'b0100, 2'd2}) begin
      miscompares++;
      $display("FAIL t2_grant: gnt=%b id=%0d, want 0100 2", gnt, res_id);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, 9'h1FE, 2'd2}) begin
      miscompares++;
      $display("FAIL t2_carry: vld=%b data=%h id=%0d, want 1 1fe 2", res_valid, res_data, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("carry: req2 255+255 -> %h", res_data);
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_gnt;
    int id;
    tick();
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(i), 8'd100);
    req = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      exp_gnt = 4'b0001 << id;
      tick();
      vectors++;
      if ({gnt, busy} !== {exp_gnt, 1'b1}) begin
        miscompares++;
        $display("FAIL t3_grant%0d: gnt=%b busy=%b, want %b 1", k, gnt, busy, exp_gnt);
      end
      tick();
      vectors++;
      if ({gnt, res_valid, res_data, res_id} !== {4'b0000, 1'b1, 9'(100 + id), 2'(id)}) begin
        miscompares++;
        $display("FAIL t3_result%0d: gnt=%b vld=%b data=%0d id=%0d, want 0000 1 %0d %0d",
                 k, gnt, res_valid, res_data, res_id, 100 + id, id);
      end
      tick();
      vectors++;
      if ({busy, res_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL t3_idle%0d: busy=%b vld=%b, want 0 0", k, busy, res_valid);
      end
      $display("back_to_back: op %0d gnt %b data %0d", k, exp_gnt, res_data);
    end
    req = 4'b0000;
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    set_op(1, 8'd127, 8'd120);
    req = 4'b0010;
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL t4_grant: gnt=%b, want 0010", gnt);
    end
    req = 4'b1000;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({gnt, busy, res_valid, res_data, res_id} !== {4'b0000, 1'b1, 1'b1, 9'd247, 2'd1}) begin
        miscompares++;
        $display("FAIL t4_hold%0d: gnt=%b busy=%b vld=%b data=%0d id=%0d, want 0000 1 1 247 1",
                 c, gnt, busy, res_valid, res_data, res_id);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_accept: vld=%b, want 0", res_valid);
    end
    tick();
    vectors++;
    if ({gnt, res_id} !== {4'b1000, 2'd3}) begin
      miscompares++;
      $display("FAIL t4_next_grant: gnt=%b id=%0d, want 1000 3", gnt, res_id);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({res_valid, res_data} !== {1'b1, 9'd103}) begin
      miscompares++;
      $display("FAIL t4_next_result: vld=%b data=%0d, want 1 103", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("backpressure: held 247 for 5 cycles, then gnt 1000");
  endtask

  task automatic test_async_reset;
    set_op(1, 8'd100, 8'd55);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, busy, res_valid, res_data, res_id} !== 17'd0) begin
      miscompares++;
      $display("FAIL t5_async_reset: gnt=%b busy=%b vld=%b data=%0d id=%0d, want all 0",
               gnt, busy, res_valid, res_data, res_id);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, res_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL t5_no_result: busy=%b vld=%b, want 0 0", busy, res_valid);
    end
    req = 4'b1111;
    tick();
    req = 4'b0000;
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL t5_ptr_reset: gnt=%b, want 0001", gnt);
    end
    tick();
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, 9'd100, 2'd0}) begin
      miscompares++;
      $display("FAIL t5_after: vld=%b data=%0d id=%0d, want 1 100 0", res_valid, res_data, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("async_reset: op discarded, ptr restarted");
  endtask

  task automatic test_drop_req;
    gnt3_seen = 1'b0;
    set_op(0, 8'd20, 8'd30);
    req = 4'b0001;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL t6_grant: gnt=%b, want 0001", gnt);
    end
    req = 4'b1000;
    tick();
    req = 4'b0000;
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, 9'd50, 2'd0}) begin
      miscompares++;
      $display("FAIL t6_result: vld=%b data=%0d id=%0d, want 1 50 0", res_valid, res_data, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if ({gnt3_seen, busy, res_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL t6_dropped: gnt3_seen=%b busy=%b vld=%b, want 0 0 0", gnt3_seen, busy, res_valid);
    end
    $display("drop_req: only requester 0 served");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    gnt3_seen = 1'b0;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
